// File: rtl/parser_pkg.sv
// Shared types and constants for the parser and its rule-configuration loader.
package parser_pkg;

    // Configuration loader sequencer states
    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_FETCH,
        CFG_LATCH,
        CFG_WRITE,
        CFG_READ,
        CFG_WAIT_RD,
        CFG_NEXT,
        CFG_DONE
    } cfg_state_t;

    // Rule-port selector, carried in rule_addr[10:8]
    localparam logic [2:0] RULE_SEL_RULE   = 3'd0;
    localparam logic [2:0] RULE_SEL_TYPE   = 3'd1;
    localparam logic [2:0] RULE_SEL_TOFF   = 3'd2;
    localparam logic [2:0] RULE_SEL_KOFF   = 3'd3;
    localparam logic [2:0] RULE_SEL_HSHIFT = 3'd4;
    localparam logic [2:0] RULE_SEL_MSHIFT = 3'd5;

    // One entry-table word: {rule_addr[63:32], rule_wdata[31:0]}
    localparam int CFG_ENTRY_W = 64;

    // Loader completion codes
    localparam logic [1:0] CFG_ERR_OK       = 2'd0;
    localparam logic [1:0] CFG_ERR_MISMATCH = 2'd1;
    localparam logic [1:0] CFG_ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/parser_cfg_loader.sv
// Walks an entry table in external synchronous memory and programs the parser
// rule port one entry at a time, optionally reading each entry back to verify.
module parser_cfg_loader
    import parser_pkg::*;
#(
    parameter int ENTRY_AW = 8,
    parameter int VERIFY   = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ENTRY_AW:0]      i_entry_cnt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_err_code,
    output logic [ENTRY_AW-1:0]    o_err_idx,
    output logic [ENTRY_AW-1:0]    o_mem_addr,
    input  logic [CFG_ENTRY_W-1:0] i_mem_rdata,
    output logic                   o_rule_wren,
    output logic                   o_rule_rden,
    output logic [31:0]            o_rule_addr,
    output logic [31:0]            o_rule_wdata,
    input  logic                   i_rule_rdata_valid,
    input  logic [31:0]            i_rule_rdata
);

    localparam int             TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

    cfg_state_t          state;
    cfg_state_t          state_nx;
    logic [ENTRY_AW:0]   idx;
    logic [ENTRY_AW:0]   cnt;
    logic [ENTRY_AW:0]   idx_inc;
    logic [TW-1:0]       tcnt;
    logic [31:0]         rule_addr;
    logic [31:0]         rule_wdata;
    logic [1:0]          err_code;
    logic [1:0]          err_code_nx;
    logic [ENTRY_AW-1:0] err_idx;
    logic                done;
    logic                verify_entry;
    logic                rd_match;
    logic                rd_timeout;

    // idx is one bit wider than the table address so a full table terminates
    assign idx_inc      = idx + 1'b1;
    assign verify_entry = (VERIFY != 0) && (rule_addr[10:8] != RULE_SEL_RULE);
    assign rd_match     = (i_rule_rdata == rule_wdata);
    assign rd_timeout   = (tcnt == T_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= CFG_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and completion code
    always_comb begin
        state_nx    = state;
        err_code_nx = CFG_ERR_OK;
        case (state)
            CFG_IDLE: begin
                if (i_start) begin
                    state_nx = (i_entry_cnt == '0) ? CFG_DONE : CFG_FETCH;
                end
            end
            CFG_FETCH: state_nx = CFG_LATCH;
            CFG_LATCH: state_nx = CFG_WRITE;
            CFG_WRITE: state_nx = verify_entry ? CFG_READ : CFG_NEXT;
            CFG_READ:  state_nx = CFG_WAIT_RD;
            CFG_WAIT_RD: begin
                // Valid data takes priority over an expiring timeout
                if (i_rule_rdata_valid) begin
                    if (rd_match) begin
                        state_nx = CFG_NEXT;
                    end else begin
                        state_nx    = CFG_DONE;
                        err_code_nx = CFG_ERR_MISMATCH;
                    end
                end else if (rd_timeout) begin
                    state_nx    = CFG_DONE;
                    err_code_nx = CFG_ERR_TIMEOUT;
                end
            end
            CFG_NEXT:  state_nx = (idx_inc == cnt) ? CFG_DONE : CFG_FETCH;
            CFG_DONE:  state_nx = CFG_IDLE;
            default:   state_nx = CFG_IDLE;
        endcase
    end

    // Datapath: count/index, latched entry, timeout counter and status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            tcnt       <= '0;
            rule_addr  <= '0;
            rule_wdata <= '0;
            err_code   <= CFG_ERR_OK;
            err_idx    <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (i_start) begin
                        cnt      <= i_entry_cnt;
                        idx      <= '0;
                        done     <= 1'b0;
                        err_code <= CFG_ERR_OK;
                        err_idx  <= '0;
                    end
                end
                CFG_LATCH: begin
                    rule_addr  <= i_mem_rdata[63:32];
                    rule_wdata <= i_mem_rdata[31:0];
                end
                CFG_READ:    tcnt <= '0;
                CFG_WAIT_RD: tcnt <= tcnt + 1'b1;
                CFG_NEXT:    idx  <= idx_inc;
                default: ;
            endcase
            // Status is captured on entry to DONE so it is valid while DONE is held
            if (state != CFG_DONE && state_nx == CFG_DONE) begin
                done     <= 1'b1;
                err_code <= err_code_nx;
                if (err_code_nx != CFG_ERR_OK) begin
                    err_idx <= idx[ENTRY_AW-1:0];
                end
            end
        end
    end

    assign o_busy       = (state != CFG_IDLE);
    assign o_done       = done;
    assign o_err_code   = err_code;
    assign o_err_idx    = err_idx;
    assign o_mem_addr   = idx[ENTRY_AW-1:0];
    assign o_rule_wren  = (state == CFG_WRITE);
    assign o_rule_rden  = (state == CFG_READ);
    assign o_rule_addr  = rule_addr;
    assign o_rule_wdata = rule_wdata;

endmodule

// File: tb/tb_parser_cfg_loader.sv
// Bench for parser_cfg_loader: one instance without readback, one with.
module tb_parser_cfg_loader;
    import parser_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n;
    logic          start0, start1;
    logic [AW:0]   ent_cnt;
    logic [63:0]   mem_rdata;
    logic          rvalid;
    logic [31:0]   rdata;

    logic          busy0, done0, wren0, rden0;
    logic [1:0]    err0;
    logic [AW-1:0] eidx0, maddr0;
    logic [31:0]   raddr0, wdata0;
    logic          busy1, done1, wren1, rden1;
    logic [1:0]    err1;
    logic [AW-1:0] eidx1, maddr1;
    logic [31:0]   raddr1, wdata1;

    parser_cfg_loader #(.ENTRY_AW(AW), .VERIFY(0), .TIMEOUT(16)) u_dut_nv (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_entry_cnt(ent_cnt),
        .o_busy(busy0), .o_done(done0), .o_err_code(err0), .o_err_idx(eidx0),
        .o_mem_addr(maddr0), .i_mem_rdata(mem_rdata),
        .o_rule_wren(wren0), .o_rule_rden(rden0), .o_rule_addr(raddr0),
        .o_rule_wdata(wdata0), .i_rule_rdata_valid(rvalid), .i_rule_rdata(rdata)
    );

    parser_cfg_loader #(.ENTRY_AW(AW), .VERIFY(1), .TIMEOUT(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_entry_cnt(ent_cnt),
        .o_busy(busy1), .o_done(done1), .o_err_code(err1), .o_err_idx(eidx1),
        .o_mem_addr(maddr1), .i_mem_rdata(mem_rdata),
        .o_rule_wren(wren1), .o_rule_rden(rden1), .o_rule_addr(raddr1),
        .o_rule_wdata(wdata1), .i_rule_rdata_valid(rvalid), .i_rule_rdata(rdata)
    );

    int            sel = 0;
    logic          obs_busy, obs_done, obs_wren, obs_rden;
    logic [1:0]    obs_err;
    logic [AW-1:0] obs_eidx, obs_maddr;
    logic [31:0]   obs_raddr, obs_wdata;

    always_comb begin
        obs_busy  = sel ? busy1  : busy0;
        obs_done  = sel ? done1  : done0;
        obs_wren  = sel ? wren1  : wren0;
        obs_rden  = sel ? rden1  : rden0;
        obs_err   = sel ? err1   : err0;
        obs_eidx  = sel ? eidx1  : eidx0;
        obs_maddr = sel ? maddr1 : maddr0;
        obs_raddr = sel ? raddr1 : raddr0;
        obs_wdata = sel ? wdata1 : wdata0;
    end

    // Entry table and per-entry readback behaviour (lat 0 = never answers)
    logic [63:0] mem [0:255];
    int          lat [0:255];
    bit          bad [0:255];
    logic [31:0] bad_data [0:255];

    int errors = 0;
    int checks = 0;

    int          exp_wc[$], exp_rc[$], act_wc[$], act_rc[$];
    logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_rd[$];
    logic [31:0] act_wa[$], act_wd[$], act_ra[$], act_rd[$];
    int          exp_done, exp_err, exp_eidx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wren"},  obs_wren,  0);
        chk({tag, "_rden"},  obs_rden,  0);
        chk({tag, "_busy"},  obs_busy,  0);
        chk({tag, "_done"},  obs_done,  0);
        chk({tag, "_err"},   obs_err,   0);
        chk({tag, "_eidx"},  obs_eidx,  0);
        chk({tag, "_maddr"}, obs_maddr, 0);
        chk({tag, "_raddr"}, obs_raddr, 0);
        chk({tag, "_wdata"}, obs_wdata, 0);
    endtask

    // Expected transaction schedule from the per-entry cycle budget:
    // FETCH, LATCH, WRITE, NEXT; verified entries add READ plus N WAIT_RD cycles.
    task automatic model(input int v, input int n, input int s);
        int t;
        logic [31:0] a, d;
        exp_wc.delete(); exp_wa.delete(); exp_wd.delete();
        exp_rc.delete(); exp_ra.delete(); exp_rd.delete();
        exp_err = 0; exp_eidx = 0;
        t = s + 1;
        for (int e = 0; e < n; e++) begin
            a = mem[e][63:32];
            d = mem[e][31:0];
            exp_wc.push_back(t + 2); exp_wa.push_back(a); exp_wd.push_back(d);
            if (v != 0 && a[10:8] != 3'd0) begin
                exp_rc.push_back(t + 3); exp_ra.push_back(a); exp_rd.push_back(d);
                if (lat[e] < 1 || lat[e] > 16) begin
                    exp_err = 2; exp_eidx = e; t = t + 4 + 16; break;
                end
                if (bad[e] && bad_data[e] != d) begin
                    exp_err = 1; exp_eidx = e; t = t + 4 + lat[e]; break;
                end
                t = t + 5 + lat[e];
            end else begin
                t = t + 4;
            end
        end
        exp_done = t;
    endtask

    task automatic fill_random(input int n);
        logic [31:0] a, d;
        int r;
        for (int e = 0; e < n; e++) begin
            a = $urandom;
            a[10:8] = 3'($urandom_range(0, 7));
            d = $urandom;
            mem[e] = {a, d};
            r = $urandom_range(0, 29);
            lat[e] = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 17 : $urandom_range(1, 4);
            bad[e] = ($urandom_range(0, 15) == 0);
            bad_data[e] = d ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    task automatic run_load(input string tag, input int v, input int n,
                            input bit poke_busy, input bit poke_done);
        int s, c, due, ent;
        bit pend, got_done;
        logic [31:0] resp;
        logic [AW-1:0] prev;
        act_wc.delete(); act_wa.delete(); act_wd.delete();
        act_rc.delete(); act_ra.delete(); act_rd.delete();
        sel = v;
        @(negedge clk);
        chk({tag, "_idle_before"}, obs_busy, 0);
        ent_cnt = (AW+1)'(n);
        if (v != 0) start1 = 1'b1; else start0 = 1'b1;
        s = cyc;
        prev = obs_maddr;
        pend = 0; due = 0; resp = '0; got_done = 0;
        model(v, n, s);
        for (int k = 0; k < 3000 && !got_done; k++) begin
            @(negedge clk);
            c = cyc;
            start0 = 1'b0; start1 = 1'b0;
            ent_cnt = (AW+1)'($urandom);
            mem_rdata = mem[prev];
            prev = obs_maddr;
            chk({tag, "_strobe_excl"}, obs_wren & obs_rden, 0);
            if (obs_wren) begin
                act_wc.push_back(c); act_wa.push_back(obs_raddr); act_wd.push_back(obs_wdata);
            end
            if (obs_rden) begin
                act_rc.push_back(c); act_ra.push_back(obs_raddr); act_rd.push_back(obs_wdata);
                ent = act_wc.size() - 1;
                if (ent >= 0 && lat[ent] != 0) begin
                    pend = 1; due = c + lat[ent];
                    resp = bad[ent] ? bad_data[ent] : mem[ent][31:0];
                end
            end
            rvalid = 1'b0;
            rdata = $urandom;
            if (pend && c == due) begin
                rvalid = 1'b1; rdata = resp; pend = 0;
            end
            if (poke_busy && n > 0 && c == s + 3) begin
                if (v != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            if (obs_done) begin
                got_done = 1;
                chk({tag, "_done_cycle"}, c - s, exp_done - s);
                chk({tag, "_busy_in_done"}, obs_busy, 1);
                chk({tag, "_err_code"}, obs_err, exp_err);
                if (exp_err != 0) chk({tag, "_err_idx"}, obs_eidx, exp_eidx);
                if (poke_done) begin
                    if (v != 0) start1 = 1'b1; else start0 = 1'b1;
                end
            end
        end
        chk({tag, "_done_seen"}, got_done, 1);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; rvalid = 1'b0;
        chk({tag, "_idle_after"}, obs_busy, 0);
        chk({tag, "_done_held"}, obs_done, 1);
        chk({tag, "_err_held"}, obs_err, exp_err);
        chk({tag, "_wren_cnt"}, act_wc.size(), exp_wc.size());
        for (int i = 0; i < act_wc.size() && i < exp_wc.size(); i++) begin
            chk({tag, "_wren_cyc"},  act_wc[i] - s, exp_wc[i] - s);
            chk({tag, "_wren_addr"}, act_wa[i], exp_wa[i]);
            chk({tag, "_wren_data"}, act_wd[i], exp_wd[i]);
        end
        chk({tag, "_rden_cnt"}, act_rc.size(), exp_rc.size());
        for (int i = 0; i < act_rc.size() && i < exp_rc.size(); i++) begin
            chk({tag, "_rden_cyc"},  act_rc[i] - s, exp_rc[i] - s);
            chk({tag, "_rden_addr"}, act_ra[i], exp_ra[i]);
            chk({tag, "_rden_data"}, act_rd[i], exp_rd[i]);
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1; ent_cnt = 9'd3;
        mem_rdata = '0; rvalid = 1'b0; rdata = '0;
        for (int e = 0; e < 256; e++) begin
            mem[e] = '0; lat[e] = 1; bad[e] = 0; bad_data[e] = '0;
        end

        // Reset held with start asserted
        repeat (3) @(negedge clk);
        sel = 0; #1; chk_zero("rst_nv");
        sel = 1; #1; chk_zero("rst_vf");
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy0, busy1, wren0, wren1, rden0, rden1}, 0);
        end

        // Three entries, no readback
        mem[0] = {32'h0000_0200, 32'h0000_0C0D};
        mem[1] = {32'h0000_0400, 32'h0000_0007};
        mem[2] = {32'h0000_0500, 32'h0000_0006};
        run_load("three_nv", 0, 3, 0, 0);

        // Readback pass with a write-only entry in the middle, start poked while busy
        mem[0] = {32'h0000_0200, 32'h1111_0001}; lat[0] = 2;
        mem[1] = {32'h0000_0010, 32'h2222_0002}; lat[1] = 2;
        mem[2] = {32'h0000_0500, 32'h3333_0003}; lat[2] = 2;
        mem[3] = {32'h0000_0100, 32'h4444_0004}; lat[3] = 16;
        run_load("verify_pass", 1, 4, 1, 0);

        // Mismatch on entry 2
        for (int e = 0; e < 4; e++) begin
            mem[e] = {32'h0000_0100 + 32'(e << 8), 32'h0ABC_0000 + 32'(e)};
            lat[e] = 2; bad[e] = 0;
        end
        bad[2] = 1; bad_data[2] = 32'h0000_DEAD;
        run_load("mismatch", 1, 4, 0, 1);
        bad[2] = 0;

        // Readback never answered
        mem[0] = {32'h0000_0300, 32'h5555_AAAA}; lat[0] = 0;
        run_load("timeout", 1, 2, 0, 0);

        // Empty table on both instances, start in the DONE cycle
        run_load("count0_vf", 1, 0, 0, 1);
        run_load("count0_nv", 0, 0, 0, 1);

        // Full table without wrap
        fill_random(256);
        run_load("full_table", 0, 256, 1, 1);

        // Randomized loads
        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 10);
            fill_random(n);
            run_load("rand_vf", 1, n, r[0], r[1]);
        end
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 10);
            fill_random(n);
            run_load("rand_nv", 0, n, 0, r[0]);
        end

        // Reset while waiting for readback
        sel = 1;
        mem[0] = {32'h0000_0300, 32'h1234_5678}; lat[0] = 0;
        @(negedge clk);
        ent_cnt = 9'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; mem_rdata = mem[0];
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (obs_rden) found = 1;
            @(negedge clk);
        end
        chk("midrst_reached_read", found, 1);
        repeat (2) @(negedge clk);
        chk("midrst_busy_before", obs_busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_quiet", {obs_busy, obs_wren, obs_rden}, 0);
        end

        // Normal operation after the aborted load
        fill_random(5);
        run_load("after_rst", 1, 5, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
